// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the GCD job scheduler and its arbiter.
package gcd_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultNumReq = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } gcd_sched_state_t;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester after last_grant_i.
module gcd_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_valid_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  int unsigned idx;

  // Walk the ring from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    idx         = 0;
    for (int unsigned k = NumReq; k >= 1; k--) begin
      idx = (32'(last_grant_i) + k) % NumReq;
      if (req_valid_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Round-robin front end sharing one start/done GCD engine between NUM_REQ requesters.
// Define GCD_ZERO_GUARD_EN to answer zero-operand jobs directly without using the engine.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_a,
  output logic [WIDTH-1:0]         eng_b,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_gcd,
  output logic                     rsp_zero
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  gcd_sched_state_t state_q, state_d;
  logic [IdxW-1:0]  last_grant_q, last_grant_d;
  logic [IdxW-1:0]  id_q, id_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d;
  logic [WIDTH-1:0] eng_b_q, eng_b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic [WIDTH-1:0]   sel_a, sel_b;
`ifdef GCD_ZERO_GUARD_EN
  logic zero_q, zero_d;
`endif

  gcd_rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign sel_a = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b = req_b[grant_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    gcd_d        = gcd_q;
`ifdef GCD_ZERO_GUARD_EN
    zero_d       = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          eng_a_d      = sel_a;
          eng_b_d      = sel_b;
          state_d      = StLaunch;
`ifdef GCD_ZERO_GUARD_EN
          zero_d       = 1'b0;
          // The subtractive engine never terminates on a zero operand.
          if (sel_a == '0 || sel_b == '0) begin
            gcd_d   = sel_a | sel_b;
            zero_d  = ~|(sel_a | sel_b);
            state_d = StResp;
          end
`endif
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (eng_done) begin
          gcd_d   = eng_result;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      id_q         <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      gcd_q        <= '0;
`ifdef GCD_ZERO_GUARD_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      gcd_q        <= gcd_d;
`ifdef GCD_ZERO_GUARD_EN
      zero_q       <= zero_d;
`endif
    end
  end

  assign req_ready = (state_q == StIdle) ? grant : '0;
  assign eng_start = (state_q == StLaunch);
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = ID_W'(id_q);
  assign rsp_gcd   = gcd_q;
`ifdef GCD_ZERO_GUARD_EN
  assign rsp_zero  = zero_q;
`else
  assign rsp_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Scoreboard bench for gcd_job_scheduler with a behavioural engine and round-robin model.
module tb_gcd_job_scheduler;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  typedef struct {
    int id;
    int gcd;
    int zero;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic          eng_start;
  logic [W-1:0]  eng_a, eng_b;
  logic          eng_done = 1'b0;
  logic [W-1:0]  eng_result = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IW-1:0] rsp_id;
  logic [W-1:0]  rsp_gcd;
  logic          rsp_zero;

  gcd_job_scheduler #(
    .NUM_REQ (NR),
    .WIDTH   (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_gcd    (rsp_gcd),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected behaviour
  rsp_t     exp_q[$];
  int       grant_log[$];
  int       m_last = NR - 1;
  bit       m_busy, m_start_exp, m_wait, m_rsp_exp, m_held;
  rsp_t     held;
  logic [W-1:0] m_ea, m_eb;
  int       start_count, rsp_count, last_id, last_gcd;
  bit       acc_flag[NR];

  // Engine model and stimulus knobs
  bit       eng_busy, spur_mode, spur_pend;
  int       eng_cnt;
  logic [W-1:0] eng_res;
  int       lat_min, lat_max;
  int       remaining[NR];
  int       p_req, p_drop, p_rdy, p_zero;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    int unsigned f;
    if ($urandom_range(99) < p_zero) return '0;
    f = $urandom_range(50, 1);
    return W'(f * $urandom_range(40, 1));
  endfunction

  task automatic sample();
    logic [NR-1:0] exp_grant;
    int g;
    logic [W-1:0] a, b;
    rsp_t e;
    bit start_n, wait_n, rexp_n;
    if (!rst_n) begin
      if (req_valid == '0) check("reset_req_ready", req_ready, 0);
      check("reset_eng_start", eng_start, 0);
      check("reset_eng_a", eng_a, 0);
      check("reset_eng_b", eng_b, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_gcd", rsp_gcd, 0);
      check("reset_rsp_zero", rsp_zero, 0);
      exp_q.delete();
      m_last = NR - 1;
      {m_busy, m_start_exp, m_wait, m_rsp_exp, m_held, spur_pend} = '0;
      for (int i = 0; i < NR; i++) acc_flag[i] = 1'b0;
      return;
    end
    exp_grant = '0;
    g = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (req_valid[idx]) begin
          g = idx;
          break;
        end
      end
    end
    if (g >= 0) exp_grant[g] = 1'b1;
    check("req_ready", req_ready, exp_grant);
    check("eng_start", eng_start, m_start_exp);
    if (m_start_exp || m_wait) begin
      check("eng_a", eng_a, m_ea);
      check("eng_b", eng_b, m_eb);
    end
    check("rsp_valid", rsp_valid, m_rsp_exp);
    if (eng_start) begin
      start_count++;
      eng_busy = 1'b1;
      eng_cnt  = $urandom_range(lat_max, lat_min);
      eng_res  = ref_gcd(eng_a, eng_b);
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_flag[i] = 1'b1;
        grant_log.push_back(i);
      end
    end
    if (m_rsp_exp && m_held) begin
      check("hold_rsp_id", rsp_id, held.id);
      check("hold_rsp_gcd", rsp_gcd, held.gcd);
      check("hold_rsp_zero", rsp_zero, held.zero);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      last_id  = rsp_id;
      last_gcd = rsp_gcd;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_gcd", rsp_gcd, e.gcd);
        check("rsp_zero", rsp_zero, e.zero);
      end
    end
    m_held = m_rsp_exp && rsp_valid && !rsp_ready;
    held.id = rsp_id;
    held.gcd = rsp_gcd;
    held.zero = rsp_zero;

    start_n = 1'b0;
    wait_n  = m_wait;
    rexp_n  = m_rsp_exp;
    if (m_start_exp) wait_n = 1'b1;
    if (m_wait && eng_done) begin
      wait_n = 1'b0;
      rexp_n = 1'b1;
    end
    if (m_rsp_exp && rsp_ready) begin
      rexp_n = 1'b0;
      m_busy = 1'b0;
    end
    if (g >= 0) begin
      a = req_a[g*W +: W];
      b = req_b[g*W +: W];
      m_last = g;
      m_busy = 1'b1;
      m_ea = a;
      m_eb = b;
      e.id = g;
`ifdef GCD_ZERO_GUARD_EN
      if (a == '0 || b == '0) begin
        e.gcd  = int'(a | b);
        e.zero = ((a | b) == '0) ? 1 : 0;
        rexp_n = 1'b1;
      end else
`endif
      begin
        e.gcd  = int'(ref_gcd(a, b));
        e.zero = 0;
        start_n = 1'b1;
      end
      exp_q.push_back(e);
      if (spur_mode) begin
        spur_pend = 1'b1;
        spur_mode = 1'b0;
      end
    end
    m_start_exp = start_n;
    m_wait      = wait_n;
    m_rsp_exp   = rexp_n;
  endtask

  // Engine drive at the falling edge, observation 4 ns later (1 ns before the rising edge).
  initial begin
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_busy) begin
        if (eng_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = eng_res;
          eng_busy   = 1'b0;
        end else eng_cnt--;
      end
      if (spur_pend) begin
        eng_done   = 1'b1;
        eng_result = 16'hbeef;
        spur_pend  = 1'b0;
      end
      #4;
      sample();
    end
  end

  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i]  = 1'b0;
        req_valid[i] = 1'b0;
        if (remaining[i] > 0) remaining[i]--;
      end
      if (!req_valid[i] && remaining[i] > 0 && $urandom_range(99) < p_req) begin
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = rand_op();
        req_b[i*W +: W]  = rand_op();
      end else if (req_valid[i] && $urandom_range(99) < p_drop) begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(99) < p_rdy);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (remaining[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_drained(input string name, input int max_cycles);
    int n = 0;
    while ((pending() || m_busy || req_valid != '0) && n < max_cycles) begin
      drive_cycle();
      n++;
    end
    check({name, "_drain"}, (n < max_cycles) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_job(input int i, input int a, input int b);
    @(negedge clk);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i]    = 1'b1;
    remaining[i]    = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int s0, r0, a0, n;
    p_req = 100; p_drop = 0; p_rdy = 100; p_zero = 0;
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < NR; i++) remaining[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request from requester 2
    lat_min = 10; lat_max = 10;
    s0 = start_count; r0 = rsp_count;
    set_job(2, 48, 18);
    run_until_drained("single", 100);
    check("single_starts", start_count - s0, 1);
    check("single_rsps", rsp_count - r0, 1);
    check("single_id", last_id, 2);
    check("single_gcd", last_gcd, 6);

    // Round-robin with all requesters continuously valid
    do_reset(2);
    grant_log.delete();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < NR; i++) remaining[i] = 2;
    run_until_drained("rr", 400);
    check("rr_count", grant_log.size(), 8);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) check("rr_order", grant_log[k], k % NR);

    // Backpressure: response held while rsp_ready stays low
    lat_min = 2; lat_max = 2; p_rdy = 0;
    s0 = start_count; a0 = grant_log.size();
    remaining[1] = 1; remaining[3] = 1;
    repeat (28) drive_cycle();
    check("bp_accepts", grant_log.size() - a0, 1);
    check("bp_starts", start_count - s0, 1);
    check("bp_rsp_held", rsp_valid, 1);
    p_rdy = 100;
    run_until_drained("bp", 100);

    // Reset during WAIT, then a stale done from the aborted run
    lat_min = 15; lat_max = 15;
    r0 = rsp_count;
    remaining[1] = 1;
    n = 0;
    while (!m_wait && n < 50) begin drive_cycle(); n++; end
    check("mid_wait_reached", m_wait, 1);
    repeat (3) drive_cycle();
    do_reset(1);
    n = 0;
    while (eng_busy && n < 50) begin drive_cycle(); n++; end
    check("mid_stale_done_issued", eng_busy, 0);
    repeat (3) drive_cycle();
    check("mid_no_rsp", rsp_count - r0, 0);
    lat_min = 0; lat_max = 2;
    a0 = grant_log.size();
    for (int i = 0; i < NR; i++) remaining[i] = 1;
    run_until_drained("post_reset", 200);
    if (grant_log.size() > a0) check("post_reset_first", grant_log[a0], 0);
    else check("post_reset_grants", grant_log.size() - a0, 4);

    // Done pulse during LAUNCH must be ignored
    lat_min = 3; lat_max = 3;
    spur_mode = 1'b1;
    set_job(3, 84, 60);
    run_until_drained("late", 100);
    check("late_gcd", last_gcd, 12);

`ifdef GCD_ZERO_GUARD_EN
    s0 = start_count;
    set_job(0, 0, 35);
    run_until_drained("zero_a", 50);
    check("zero_a_gcd", last_gcd, 35);
    set_job(0, 0, 0);
    run_until_drained("zero_both", 50);
    check("zero_both_gcd", last_gcd, 0);
    check("zero_starts", start_count - s0, 0);
    p_zero = 15;
`endif

    // Randomised traffic with drops and response backpressure
    p_req = 40; p_drop = 10; p_rdy = 60;
    lat_min = 0; lat_max = 6;
    for (int i = 0; i < NR; i++) remaining[i] = 15;
    run_until_drained("rand", 5000);
    repeat (3) drive_cycle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
